// File: rtl/y_buf_argmax_reader_pkg.sv
// Shared types and constants for the y-buffer argmax readout block.
package y_buf_argmax_reader_pkg;

   localparam int unsigned NUM_CLASS_DFLT  = 10;
   localparam int unsigned IN_IMG_NUM_DFLT = 10;
   localparam int unsigned ADDR_STRIDE     = 4;
   localparam int unsigned LABEL_W         = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_EMIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/y_buf_argmax_reader_argmax_unit.sv
// argmax_unit: running signed maximum and its class index.
// init loads unconditionally; update replaces only on a strictly greater score.
module y_buf_argmax_reader_argmax_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              init_i,
   input  logic              update_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] max_o,
   output logic [IDX_W-1:0]  idx_o
);

   logic [DATA_W-1:0] max_q, max_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   // Strict compare keeps the lowest index on ties.
   always_comb begin
      max_d = max_q;
      idx_d = idx_q;
      if (init_i) begin
         max_d = data_i;
         idx_d = idx_i;
      end else if (update_i && ($signed(data_i) > $signed(max_q))) begin
         max_d = data_i;
         idx_d = idx_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         max_q <= '0;
         idx_q <= '0;
      end else begin
         max_q <= max_d;
         idx_q <= idx_d;
      end
   end

   assign max_o = max_q;
   assign idx_o = idx_q;

endmodule

// File: rtl/y_buf_argmax_reader.sv
// Reads NUM_CLASS signed scores per image from the y buffer and emits
// the argmax class per image over a valid/ready handshake.
module y_buf_argmax_reader
   import y_buf_argmax_reader_pkg::*;
#(
   parameter int unsigned IN_IMG_NUM       = IN_IMG_NUM_DFLT,
   parameter int unsigned NUM_CLASS        = NUM_CLASS_DFLT,
   parameter int unsigned Y_BUF_DATA_WIDTH = 32,
   parameter int unsigned Y_BUF_DEPTH      = NUM_CLASS * IN_IMG_NUM * ADDR_STRIDE
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              start_i,
   output logic                              y_buf_en,
   output logic [$clog2(Y_BUF_DEPTH)-1:0]    y_buf_addr,
   input  logic [Y_BUF_DATA_WIDTH-1:0]       y_buf_rdata,
   output logic                              label_valid_o,
   input  logic                              label_ready_i,
   output logic [LABEL_W-1:0]                label_o,
   output logic [$clog2(IN_IMG_NUM)-1:0]     img_idx_o,
   output logic [Y_BUF_DATA_WIDTH-1:0]       max_score_o,
   output logic                              busy_o,
   output logic                              done_o
);

   localparam int unsigned ADDR_W = $clog2(Y_BUF_DEPTH);
   localparam int unsigned IMG_W  = $clog2(IN_IMG_NUM);

   state_e              state_q, state_d;
   logic [LABEL_W-1:0]  cls_q, cls_d;
   logic [IMG_W-1:0]    img_q, img_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                en_q, en_d;
   logic                valid_q, valid_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                rd_vld_q, rd_first_q;
   logic [LABEL_W-1:0]  rd_cls_q;

   // Images are stored back to back, so a single running pointer walks
   // the buffer; it only rewinds at the end of a run.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      img_d   = img_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      en_d    = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_READ;
               img_d   = '0;
               cls_d   = '0;
               en_d    = 1'b1;
               addr_d  = '0;
               ptr_d   = ADDR_W'(ADDR_STRIDE);
            end
         end
         ST_READ: begin
            if (cls_q == LABEL_W'(NUM_CLASS - 1)) begin
               state_d = ST_DRAIN;
            end else begin
               cls_d  = cls_q + LABEL_W'(1);
               en_d   = 1'b1;
               addr_d = ptr_q;
               ptr_d  = ptr_q + ADDR_W'(ADDR_STRIDE);
            end
         end
         ST_DRAIN: begin
            state_d = ST_EMIT;
            valid_d = 1'b1;
         end
         ST_EMIT: begin
            if (valid_q && label_ready_i) begin
               if (img_q == IMG_W'(IN_IMG_NUM - 1)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_READ;
                  img_d   = img_q + IMG_W'(1);
                  cls_d   = '0;
                  en_d    = 1'b1;
                  addr_d  = ptr_q;
                  ptr_d   = ptr_q + ADDR_W'(ADDR_STRIDE);
               end
            end else begin
               valid_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            img_d   = '0;
            ptr_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Read data lands one cycle after the enable; the rd_* stage tags it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cls_q      <= '0;
         img_q      <= '0;
         ptr_q      <= '0;
         addr_q     <= '0;
         en_q       <= 1'b0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_first_q <= 1'b0;
         rd_cls_q   <= '0;
      end else begin
         state_q    <= state_d;
         cls_q      <= cls_d;
         img_q      <= img_d;
         ptr_q      <= ptr_d;
         addr_q     <= addr_d;
         en_q       <= en_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         rd_vld_q   <= en_q;
         rd_first_q <= en_q && (cls_q == '0);
         rd_cls_q   <= cls_q;
      end
   end

   y_buf_argmax_reader_argmax_unit #(
      .DATA_W (Y_BUF_DATA_WIDTH),
      .IDX_W  (LABEL_W)
   ) u_argmax_unit (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .init_i   (rd_first_q),
      .update_i (rd_vld_q),
      .idx_i    (rd_cls_q),
      .data_i   (y_buf_rdata),
      .max_o    (max_score_o),
      .idx_o    (label_o)
   );

   assign y_buf_en      = en_q;
   assign y_buf_addr    = addr_q;
   assign label_valid_o = valid_q;
   assign img_idx_o     = img_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;

endmodule

// File: doc/y_buf_argmax_reader.md
Y_BUF_ARGMAX_READER -- requirements
Module: y_buf_argmax_reader

Interface
REQ-001 SHALL have parameter IN_IMG_NUM, default 10, number of images per run.
REQ-002 SHALL have parameter NUM_CLASS, default 10, scores per image.
REQ-003 SHALL have parameter Y_BUF_DATA_WIDTH, default 32, signed score width.
REQ-004 SHALL have parameter Y_BUF_DEPTH, default NUM_CLASS*IN_IMG_NUM*4, byte-address span.
REQ-005 SHALL have port clk_i, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start_i, input, 1, one-cycle pulse to begin readout (driven by the MLP done_intr_o).
REQ-008 SHALL have port y_buf_en, output, 1, buffer read enable.
REQ-009 SHALL have port y_buf_addr, output, $clog2(Y_BUF_DEPTH), byte read address.
REQ-010 SHALL have port y_buf_rdata, input, Y_BUF_DATA_WIDTH, read data, valid one cycle after y_buf_en.
REQ-011 SHALL have port label_valid_o, input-side handshake output, 1, result valid.
REQ-012 SHALL have port label_ready_i, input, 1, downstream ready.
REQ-013 SHALL have port label_o, output, 4, argmax class index.
REQ-014 SHALL have port img_idx_o, output, $clog2(IN_IMG_NUM), image index of label_o.
REQ-015 SHALL have port max_score_o, output, Y_BUF_DATA_WIDTH, winning score.
REQ-016 SHALL have ports busy_o and done_o, output, 1 each; busy while not IDLE, done one-cycle pulse.

Function
REQ-017 SHALL implement FSM states IDLE, READ, DRAIN, EMIT, DONE.
REQ-018 IDLE -> READ when start_i=1; start_i in any other state SHALL be ignored.
REQ-019 READ SHALL assert y_buf_en for exactly NUM_CLASS consecutive cycles, address (img*NUM_CLASS + c)*4 for c = 0..NUM_CLASS-1, then go to DRAIN.
REQ-020 y_buf_en SHALL be 0 outside READ; y_buf_addr holds its last value when y_buf_en=0.
REQ-021 Read data for class c SHALL be sampled the cycle after its address is issued; c=0 initialises max/label, later classes replace only if strictly greater (signed compare); ties keep the lowest index.
REQ-022 DRAIN SHALL last one cycle (captures final class), then EMIT.
REQ-023 EMIT SHALL hold label_valid_o=1 with stable label_o, img_idx_o, max_score_o until label_valid_o && label_ready_i.
REQ-024 On handshake: if img < IN_IMG_NUM-1, increment img and go to READ the next cycle; else go to DONE.
REQ-025 DONE SHALL assert done_o for one cycle and return to IDLE; img resets to 0.
REQ-026 Latency: start_i at edge E0 -> first label_valid_o high after edge E(NUM_CLASS+2) (12 for defaults) when ready held high.
REQ-027 Per-image throughput with label_ready_i=1 SHALL be NUM_CLASS+2 cycles.

Reset
REQ-028 rst_i SHALL asynchronously force IDLE and all outputs, counters, max and label registers to 0.
REQ-029 Reset asserted mid-READ or mid-EMIT SHALL abort the run; no done_o pulse results.

Structure
REQ-030 Shared package SHALL hold the state enum, NUM_CLASS, IN_IMG_NUM and address-stride constant (4).
REQ-031 One sub-module argmax_unit (running signed max/index register with init/update strobes) SHALL be instantiated.

Verification
REQ-032 Image 0 scores {5,-3,9,9,0,1,2,3,4,8}, ready=1 -> label_o=2, max_score_o=9, valid after 12 cycles.
REQ-033 All scores negative, e.g. class 7 = -1, others = -100 -> label_o=7, max_score_o=-1 (signed compare check).
REQ-034 label_ready_i low for 5 cycles in EMIT -> outputs stable, y_buf_en=0, no address advance.
REQ-035 Full 10-image run, ready=1 -> addresses 0,4,...,396 each read once, 10 handshakes, done_o one pulse at cycle 120+1.
REQ-036 start_i pulsed during READ -> ignored; rst_i asserted at cycle 5 -> all outputs 0 immediately, next start_i reads address 0.
